reg_port_decoder: RTL and testbench

// Parametrised CPU-side register-port front end for memory-mapped peripherals
// (PPU, APU, mappers). Synchronises the bus read/write enables and registers

---
 rtl/reg_port_decoder.sv | 150 +++++++++++++++
 tb/tb_reg_port_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_port_decoder.sv
// CPU-side register-port front end: synchronises bus enables, registers their edges,
// captures address/data per access and emits one-hot strobes plus a shared write-phase latch.
module reg_port_decoder #(
  parameter int unsigned P_addr_width  = 3,
  parameter int unsigned P_data_width  = 8,
  parameter int unsigned P_sync_stages = 2,
  parameter logic [(1<<P_addr_width)-1:0] P_toggle_mask = (1<<P_addr_width)'(8'h60),
  parameter logic [(1<<P_addr_width)-1:0] P_clear_mask  = (1<<P_addr_width)'(8'h04)
) (
  input  logic                          I_clock,
  input  logic                          I_reset,
  input  logic [P_addr_width-1:0]       I_addr,
  input  logic [P_data_width-1:0]       I_data,
  input  logic                          I_wren,
  input  logic                          I_rden,
  output logic [P_addr_width-1:0]       O_addr,
  output logic [P_data_width-1:0]       O_data,
  output logic [(1<<P_addr_width)-1:0]  O_reg,
  output logic                          O_wren_rise,
  output logic                          O_wren_fall,
  output logic                          O_rden_rise,
  output logic                          O_rden_fall,
  output logic [(1<<P_addr_width)-1:0]  O_reg_wren,
  output logic [(1<<P_addr_width)-1:0]  O_reg_rden,
  output logic [(1<<P_addr_width)-1:0]  O_reg_wrrise,
  output logic [(1<<P_addr_width)-1:0]  O_reg_wrfall,
  output logic [(1<<P_addr_width)-1:0]  O_reg_rdrise,
  output logic [(1<<P_addr_width)-1:0]  O_reg_rdfall,
  output logic                          O_phase,
  output logic                          O_conflict
);

  localparam int unsigned AW = P_addr_width;
  localparam int unsigned DW = P_data_width;
  localparam int unsigned N  = 1 << P_addr_width;
  localparam int unsigned SW = (P_sync_stages == 0) ? 1 : P_sync_stages;

  logic wren_s;
  logic rden_s;

  // Enable synchronisers; depth 0 passes the bus enables straight through.
  generate
    if (P_sync_stages == 0) begin : g_nosync
      assign wren_s = I_wren;
      assign rden_s = I_rden;
    end else begin : g_sync
      logic [SW-1:0] wren_sync;
      logic [SW-1:0] rden_sync;

      always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
          wren_sync <= '0;
          rden_sync <= '0;
        end else begin
          wren_sync <= SW'({wren_sync, I_wren});
          rden_sync <= SW'({rden_sync, I_rden});
        end
      end

      assign wren_s = wren_sync[SW-1];
      assign rden_s = rden_sync[SW-1];
    end
  endgenerate

  logic          wren_d;
  logic          rden_d;
  logic          wr_rise_n;
  logic          wr_fall_n;
  logic          rd_rise_n;
  logic          rd_fall_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_n;
  logic [N-1:0]  dec_n;
  logic          phase_n;

  // Edge detect against the previous synchronised level, capture and decode.
  always_comb begin
    wr_rise_n = 1'b0;
    wr_fall_n = 1'b0;
    rd_rise_n = 1'b0;
    rd_fall_n = 1'b0;
    addr_n    = O_addr;
    data_n    = O_data;
    dec_n     = '0;

    wr_rise_n = wren_s & ~wren_d;
    wr_fall_n = ~wren_s & wren_d;
    rd_rise_n = rden_s & ~rden_d;
    rd_fall_n = ~rden_s & rden_d;

    if (wr_rise_n || rd_rise_n) begin
      addr_n = I_addr;
    end
    if (wr_rise_n) begin
      data_n = I_data;
    end
    dec_n[addr_n] = 1'b1;
  end

  // Phase advances the cycle after the rise strobe; a clear beats a toggle.
  always_comb begin
    phase_n = O_phase;
    if (|(O_reg_rdrise & P_clear_mask)) begin
      phase_n = 1'b0;
    end else if (|(O_reg_wrrise & P_toggle_mask)) begin
      phase_n = ~O_phase;
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      wren_d       <= 1'b0;
      rden_d       <= 1'b0;
      O_addr       <= '0;
      O_data       <= '0;
      O_reg        <= N'(1);
      O_wren_rise  <= 1'b0;
      O_wren_fall  <= 1'b0;
      O_rden_rise  <= 1'b0;
      O_rden_fall  <= 1'b0;
      O_reg_wren   <= '0;
      O_reg_rden   <= '0;
      O_reg_wrrise <= '0;
      O_reg_wrfall <= '0;
      O_reg_rdrise <= '0;
      O_reg_rdfall <= '0;
      O_phase      <= 1'b0;
      O_conflict   <= 1'b0;
    end else begin
      wren_d       <= wren_s;
      rden_d       <= rden_s;
      O_addr       <= addr_n;
      O_data       <= data_n;
      O_reg        <= dec_n;
      O_wren_rise  <= wr_rise_n;
      O_wren_fall  <= wr_fall_n;
      O_rden_rise  <= rd_rise_n;
      O_rden_fall  <= rd_fall_n;
      O_reg_wren   <= dec_n & {N{wren_s}};
      O_reg_rden   <= dec_n & {N{rden_s}};
      O_reg_wrrise <= dec_n & {N{wr_rise_n}};
      O_reg_wrfall <= dec_n & {N{wr_fall_n}};
      O_reg_rdrise <= dec_n & {N{rd_rise_n}};
      O_reg_rdfall <= dec_n & {N{rd_fall_n}};
      O_phase      <= phase_n;
      O_conflict   <= wren_s & rden_s;
    end
  end

endmodule

// File: tb/tb_reg_port_decoder.sv
// Bench for reg_port_decoder: directed + random bus transactions against a cycle-indexed
// reference built from input history; second instance covers zero sync depth and 4-bit addressing.
module tb_reg_port_decoder;

  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned S   = 2;
  localparam int unsigned N   = 8;
  localparam int unsigned AW0 = 4;
  localparam int unsigned N0  = 16;
  localparam int          MAXC = 4096;
  localparam logic [7:0]  TOG = 8'h60;
  localparam logic [7:0]  CLR = 8'h04;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          wren, rden;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [N-1:0]  o_reg, reg_wren, reg_rden, reg_wrrise, reg_wrfall, reg_rdrise, reg_rdfall;
  logic          wren_rise, wren_fall, rden_rise, rden_fall, phase, conflict;

  logic [AW0-1:0] addr0, o_addr0;
  logic [DW-1:0]  data0, o_data0;
  logic           wren0, rden0;
  logic [N0-1:0]  o_reg0, reg_wren0, reg_rden0, reg_wrrise0, reg_wrfall0, reg_rdrise0, reg_rdfall0;
  logic           wren_rise0, wren_fall0, rden_rise0, rden_fall0, phase0, conflict0;

  reg_port_decoder dut (
    .I_clock(clk), .I_reset(rst_n), .I_addr(addr), .I_data(data), .I_wren(wren), .I_rden(rden),
    .O_addr(o_addr), .O_data(o_data), .O_reg(o_reg),
    .O_wren_rise(wren_rise), .O_wren_fall(wren_fall), .O_rden_rise(rden_rise), .O_rden_fall(rden_fall),
    .O_reg_wren(reg_wren), .O_reg_rden(reg_rden),
    .O_reg_wrrise(reg_wrrise), .O_reg_wrfall(reg_wrfall),
    .O_reg_rdrise(reg_rdrise), .O_reg_rdfall(reg_rdfall),
    .O_phase(phase), .O_conflict(conflict)
  );

  reg_port_decoder #(.P_addr_width(4), .P_sync_stages(0)) dut0 (
    .I_clock(clk), .I_reset(rst_n), .I_addr(addr0), .I_data(data0), .I_wren(wren0), .I_rden(rden0),
    .O_addr(o_addr0), .O_data(o_data0), .O_reg(o_reg0),
    .O_wren_rise(wren_rise0), .O_wren_fall(wren_fall0), .O_rden_rise(rden_rise0), .O_rden_fall(rden_fall0),
    .O_reg_wren(reg_wren0), .O_reg_rden(reg_rden0),
    .O_reg_wrrise(reg_wrrise0), .O_reg_wrfall(reg_wrfall0),
    .O_reg_rdrise(reg_rdrise0), .O_reg_rdfall(reg_rdfall0),
    .O_phase(phase0), .O_conflict(conflict0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Recorded bus waveform, one entry per clock cycle after reset release.
  logic          win [MAXC];
  logic          rin [MAXC];
  logic [AW-1:0] ain [MAXC];
  logic [DW-1:0] din [MAXC];

  typedef struct {
    bit            w;
    bit            r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            hold;
    int            gap;
  } txn_t;

  txn_t q[$];
  txn_t cur;
  int   hold_left = 0;
  int   gap_left  = 0;

  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;
  logic          m_phase = 1'b0;

  // Synchronised level seen by cycle k: bus value S+1 cycles earlier.
  function automatic logic lvl_w(input int k);
    int j;
    j = k - 1 - int'(S);
    return (j >= 0) ? win[j] : 1'b0;
  endfunction

  function automatic logic lvl_r(input int k);
    int j;
    j = k - 1 - int'(S);
    return (j >= 0) ? rin[j] : 1'b0;
  endfunction

  task automatic add_txn(input bit w, input bit r, input int a, input int d, input int hold, input int gap);
    txn_t t;
    t.w = w; t.r = r; t.a = AW'(a); t.d = DW'(d); t.hold = hold; t.gap = gap;
    q.push_back(t);
  endtask

  task automatic drive_cycle(input int k);
    if (hold_left == 0 && gap_left == 0 && q.size() > 0) begin
      cur       = q.pop_front();
      hold_left = cur.hold;
      gap_left  = cur.gap;
    end
    if (hold_left > 0) begin
      wren = cur.w; rden = cur.r; addr = cur.a; data = cur.d;
      hold_left--;
    end else begin
      wren = 1'b0; rden = 1'b0;
      if (gap_left > 0) gap_left--;
    end
    win[k] = wren; rin[k] = rden; ain[k] = addr; din[k] = data;
  endtask

  task automatic model_check(input int k);
    logic lw, lw_p, lr, lr_p, rw, fw, rr, fr;
    logic [N-1:0] dec;
    lw = lvl_w(k); lw_p = lvl_w(k - 1);
    lr = lvl_r(k); lr_p = lvl_r(k - 1);
    rw = lw & ~lw_p; fw = ~lw & lw_p;
    rr = lr & ~lr_p; fr = ~lr & lr_p;
    if (rw || rr) m_addr = ain[k-1];
    if (rw) m_data = din[k-1];
    dec = N'(1) << m_addr;
    check("addr",     32'(o_addr),     32'(m_addr));
    check("data",     32'(o_data),     32'(m_data));
    check("reg",      32'(o_reg),      32'(dec));
    check("edges",    32'({wren_rise, wren_fall, rden_rise, rden_fall}), 32'({rw, fw, rr, fr}));
    check("reg_wren", 32'(reg_wren),   32'(lw ? dec : '0));
    check("reg_rden", 32'(reg_rden),   32'(lr ? dec : '0));
    check("wrrise",   32'(reg_wrrise), 32'(rw ? dec : '0));
    check("wrfall",   32'(reg_wrfall), 32'(fw ? dec : '0));
    check("rdrise",   32'(reg_rdrise), 32'(rr ? dec : '0));
    check("rdfall",   32'(reg_rdfall), 32'(fr ? dec : '0));
    check("phase",    32'(phase),      32'(m_phase));
    check("conflict", 32'(conflict),   32'(lw & lr));
    if (rr && CLR[m_addr]) m_phase = 1'b0;
    else if (rw && TOG[m_addr]) m_phase = ~m_phase;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    addr = '0; data = '0; wren = 1'b0; rden = 1'b0;
    addr0 = '0; data0 = '0; wren0 = 1'b0; rden0 = 1'b0;

    // Reset holds everything quiet while the bus toggles.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      wren = 1'($urandom); rden = 1'($urandom); addr = AW'($urandom);
      check("rst_strobes", 32'({reg_wrrise, reg_rdrise, reg_wren, reg_rden}), 32'(0));
      check("rst_reg", 32'(o_reg), 32'(8'h01));
      check("rst_phase", 32'(phase), 32'(0));
    end

    // Directed accesses first, then random traffic.
    add_txn(1, 0, 5, 8'hA7, 6, 4);
    add_txn(1, 0, 6, 8'h11, 4, 2);
    add_txn(1, 0, 6, 8'h22, 4, 2);
    add_txn(1, 0, 5, 8'h33, 4, 2);
    add_txn(0, 1, 2, 8'h00, 4, 2);
    add_txn(1, 0, 6, 8'h44, 4, 2);
    add_txn(1, 0, 6, 8'h45, 4, 2);
    add_txn(1, 1, 2, 8'h55, 5, 3);
    for (int i = 0; i < 150; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      add_txn(op != 1, op != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
              int'($urandom_range(3, 7)), int'($urandom_range(1, 4)));
    end

    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    model_check(0);
    drive_cycle(0);
    while (cyc < MAXC - 16 && (q.size() > 0 || hold_left > 0 || gap_left > 0)) begin
      @(posedge clk); #1;
      cyc++;
      model_check(cyc);
      drive_cycle(cyc);
    end
    for (int i = 0; i < int'(S) + 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      model_check(cyc);
      drive_cycle(cyc);
    end
    check("stim_done", 32'(q.size()), 32'(0));

    // Reset in the middle of a held write to reg 6, released with wren still high.
    addr = 3'd6; data = 8'h5A; wren = 1'b1; rden = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async", 32'({o_reg, reg_wrrise, reg_wren}), 32'({8'h01, 8'h00, 8'h00}));
    check("midrst_phase", 32'(phase), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      if (wren_rise) break;
    end
    check("midrst_latency", 32'(n), 32'(3));
    check("midrst_wrrise", 32'(reg_wrrise), 32'(8'h40));
    check("midrst_phase_new", 32'(phase), 32'(0));
    @(posedge clk); #1;
    check("midrst_toggle", 32'(phase), 32'(1));
    wren = 1'b0;

    // Zero-depth synchroniser with 16 registers: top address decodes to bit 15.
    @(posedge clk); #1;
    addr0 = 4'd15; data0 = 8'hC3; wren0 = 1'b1;
    @(posedge clk); #1;
    check("s0_wren_rise", 32'(wren_rise0), 32'(1));
    check("s0_wrrise", 32'(reg_wrrise0), 32'(16'h8000));
    check("s0_data", 32'(o_data0), 32'(8'hC3));
    wren0 = 1'b0;
    @(posedge clk); #1;
    check("s0_wrfall", 32'(reg_wrfall0), 32'(16'h8000));
    check("s0_rise_gone", 32'(reg_wrrise0), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
